// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS registers, the top NUM_RO of which are
// read-only mirrors of status_in. Independent write (AW/W) and read channel FSMs.
module axil_reg_bank #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int NUM_RO     = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr,
  input  logic [NUM_RO*DATA_WIDTH-1:0]   status_in
);

  localparam int BW     = DATA_WIDTH / 8;
  localparam int AL     = $clog2(BW);
  localparam int IDX_W  = ADDR_WIDTH - AL;
  localparam int NUM_RW = NUM_REGS - NUM_RO;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                  en;
  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [BW-1:0]         w_strb_q;

  logic                  aw_fire, w_fire, ar_fire, commit;
  logic [31:0]           w_idx, r_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [BW-1:0]         w_strb;
  logic                  w_ok, rd_ok;
  logic [NUM_REGS-1:0]   wr_mask;
  logic [DATA_WIDTH-1:0] rd_val;

  // Byte-offset bits never select anything.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_awaddr[AL-1:0], s_araddr[AL-1:0]};

  // en keeps the readys low through reset and for the first edge after it.
  assign s_awready = en && !rst && (w_state == W_IDLE) && !aw_held;
  assign s_wready  = en && !rst && (w_state == W_IDLE) && !w_held;
  assign s_arready = en && !rst && (r_state == R_IDLE);
  assign s_bvalid  = (w_state == W_RESP);
  assign s_rvalid  = (r_state == R_RESP);

  assign aw_fire = s_awvalid && s_awready;
  assign w_fire  = s_wvalid && s_wready;
  assign ar_fire = s_arvalid && s_arready;

  always_comb begin
    w_idx = '0;
    w_idx[IDX_W-1:0] = aw_held ? aw_idx_q : s_awaddr[ADDR_WIDTH-1:AL];
    w_data  = w_held ? w_data_q : s_wdata;
    w_strb  = w_held ? w_strb_q : s_wstrb;
    commit  = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
    w_ok    = (w_idx < 32'(NUM_RW));
    wr_mask = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      wr_mask[k] = commit && w_ok && (w_idx == 32'(k));
    end
    w_next = w_state;
    case (w_state)
      W_IDLE: if (commit) w_next = W_RESP;
      W_RESP: if (s_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= 1'b0;
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      s_bresp  <= RESP_OKAY;
      reg_wr   <= '0;
    end else begin
      en      <= 1'b1;
      w_state <= w_next;
      reg_wr  <= wr_mask;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        s_bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_fire) begin
          aw_held  <= 1'b1;
          aw_idx_q <= s_awaddr[ADDR_WIDTH-1:AL];
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_data_q <= s_wdata;
          w_strb_q <= s_wstrb;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i < NUM_RW) begin : g_rw
      logic [DATA_WIDTH-1:0] q;
      always_ff @(posedge clk) begin
        if (rst) begin
          q <= RESET_VAL;
        end else if (wr_mask[i]) begin
          for (int b = 0; b < BW; b++) begin
            if (w_strb[b]) q[b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
      end
      assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = q;
    end else begin : g_ro
      assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = status_in[(i-NUM_RW)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // RW slots of reg_q are registered, so a same-edge write is not yet visible here.
  always_comb begin
    r_idx = '0;
    r_idx[IDX_W-1:0] = s_araddr[ADDR_WIDTH-1:AL];
    rd_ok  = (r_idx < 32'(NUM_REGS));
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (r_idx == 32'(k)) rd_val = reg_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
    r_next = r_state;
    case (r_state)
      R_IDLE: if (ar_fire) r_next = R_RESP;
      R_RESP: if (s_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      s_rdata <= '0;
      s_rresp <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_fire) begin
        s_rdata <= rd_val;
        s_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank with default parameters
// (16 registers, indices 12..15 read-only, 32-bit data).
module tb_axil_reg_bank;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [11:0]  s_awaddr = '0;
  logic         s_awvalid = 1'b0;
  logic         s_awready;
  logic [31:0]  s_wdata = '0;
  logic [3:0]   s_wstrb = '0;
  logic         s_wvalid = 1'b0;
  logic         s_wready;
  logic [1:0]   s_bresp;
  logic         s_bvalid;
  logic         s_bready = 1'b0;
  logic [11:0]  s_araddr = '0;
  logic         s_arvalid = 1'b0;
  logic         s_arready;
  logic [31:0]  s_rdata;
  logic [1:0]   s_rresp;
  logic         s_rvalid;
  logic         s_rready = 1'b0;
  logic [511:0] reg_q;
  logic [15:0]  reg_wr;
  logic [127:0] status_in = '0;

  int checks = 0;
  int errors = 0;

  axil_reg_bank dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg_q(reg_q), .reg_wr(reg_wr), .status_in(status_in)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rq(input int idx);
    return reg_q[idx*32 +: 32];
  endfunction

  task automatic do_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [15:0] wr);
    int n;
    s_awaddr = 12'(idx * 4); s_awvalid = 1'b1;
    s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
    n = 0;
    while (!(s_awready && s_wready) && n < 20) begin tick(); n++; end
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n = 0;
    while (!s_bvalid && n < 20) begin tick(); n++; end
    if (n >= 20) begin errors++; $display("FAIL write_timeout idx=%0d: no bvalid", idx); end
    resp = s_bresp; wr = reg_wr;
    s_bready = 1'b1; tick(); s_bready = 1'b0;
  endtask

  task automatic do_read(input int idx, output logic [31:0] data, output logic [1:0] resp);
    int n;
    s_araddr = 12'(idx * 4); s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 20) begin tick(); n++; end
    tick();
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 20) begin tick(); n++; end
    if (n >= 20) begin errors++; $display("FAIL read_timeout idx=%0d: no rvalid", idx); end
    data = s_rdata; resp = s_rresp;
    s_rready = 1'b1; tick(); s_rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if ({s_awready, s_wready, s_arready} !== 3'b000) begin errors++; $display("FAIL reset_readys got=%b exp=000", {s_awready, s_wready, s_arready}); end
    checks++; if ({s_bvalid, s_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_valids got=%b exp=00", {s_bvalid, s_rvalid}); end
    checks++; if (reg_wr !== 16'h0) begin errors++; $display("FAIL reset_reg_wr got=%h exp=0", reg_wr); end
    checks++; if (rq(0) !== 32'h0 || rq(11) !== 32'h0) begin errors++; $display("FAIL reset_regs got=%h/%h exp=0", rq(0), rq(11)); end
    rst = 1'b0;
    tick();
    checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++; $display("FAIL post_reset_readys got=%b exp=111", {s_awready, s_wready, s_arready}); end
  endtask

  task automatic test_write_same_cycle();
    logic [31:0] d; logic [1:0] r;
    s_awaddr = 12'h008; s_awvalid = 1'b1;
    s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    checks++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin errors++; $display("FAIL same_cycle_b got=%b/%b exp=1/00", s_bvalid, s_bresp); end
    checks++; if (reg_wr !== 16'h0004) begin errors++; $display("FAIL same_cycle_pulse got=%h exp=0004", reg_wr); end
    checks++; if (rq(2) !== 32'h12345678) begin errors++; $display("FAIL same_cycle_reg got=%h exp=12345678", rq(2)); end
    s_bready = 1'b1; tick(); s_bready = 1'b0;
    checks++; if (s_bvalid !== 1'b0 || reg_wr !== 16'h0) begin errors++; $display("FAIL same_cycle_end got=%b/%h exp=0/0000", s_bvalid, reg_wr); end
    do_read(2, d, r);
    checks++; if (d !== 32'h12345678 || r !== 2'b00) begin errors++; $display("FAIL readback got=%h/%b exp=12345678/00", d, r); end
  endtask

  task automatic test_w_first();
    s_wdata = 32'hAABBCCDD; s_wstrb = 4'h5; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    checks++; if (s_wready !== 1'b0 || s_bvalid !== 1'b0) begin errors++; $display("FAIL w_first_held got wready=%b bvalid=%b exp=0/0", s_wready, s_bvalid); end
    tick(); tick();
    checks++; if (rq(2) !== 32'h12345678 || s_wready !== 1'b0) begin errors++; $display("FAIL w_first_wait got=%h/%b exp=12345678/0", rq(2), s_wready); end
    s_awaddr = 12'h008; s_awvalid = 1'b1;
    checks++; if (s_awready !== 1'b1) begin errors++; $display("FAIL w_first_awready got=%b exp=1", s_awready); end
    tick();
    s_awvalid = 1'b0;
    checks++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || reg_wr !== 16'h0004) begin errors++; $display("FAIL w_first_commit got=%b/%b/%h exp=1/00/0004", s_bvalid, s_bresp, reg_wr); end
    checks++; if (rq(2) !== 32'h12BB56DD) begin errors++; $display("FAIL w_first_strobe got=%h exp=12BB56DD", rq(2)); end
    s_bready = 1'b1; tick(); s_bready = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [1:0] r; logic [15:0] w;
    status_in[31:0] = 32'hCAFEF00D;
    do_write(16, 32'hFFFFFFFF, 4'hF, r, w);
    checks++; if (r !== 2'b10 || w !== 16'h0) begin errors++; $display("FAIL oor_write got=%b/%h exp=10/0000", r, w); end
    do_write(12, 32'h11111111, 4'hF, r, w);
    checks++; if (r !== 2'b10 || w !== 16'h0) begin errors++; $display("FAIL ro_write got=%b/%h exp=10/0000", r, w); end
    checks++; if (rq(2) !== 32'h12BB56DD || rq(12) !== 32'hCAFEF00D) begin errors++; $display("FAIL err_unchanged got=%h/%h exp=12BB56DD/CAFEF00D", rq(2), rq(12)); end
    do_read(16, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL oor_read got=%h/%b exp=0/10", d, r); end
    do_read(12, d, r);
    checks++; if (d !== 32'hCAFEF00D || r !== 2'b00) begin errors++; $display("FAIL ro_read got=%h/%b exp=CAFEF00D/00", d, r); end
  endtask

  task automatic test_bready_hold();
    s_awaddr = 12'h00C; s_awvalid = 1'b1;
    s_wdata = 32'h33; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    s_awaddr = 12'h010;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || s_awready !== 1'b0 || s_wready !== 1'b0) begin
        errors++; $display("FAIL bready_hold cyc=%0d got bv=%b br=%b awr=%b wr=%b exp=1/00/0/0", i, s_bvalid, s_bresp, s_awready, s_wready);
      end
      tick();
    end
    s_bready = 1'b1; tick(); s_bready = 1'b0;
    checks++; if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin errors++; $display("FAIL after_b got bv=%b awr=%b exp=0/1", s_bvalid, s_awready); end
    s_wdata = 32'h44; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    checks++; if (s_bvalid !== 1'b1 || rq(4) !== 32'h44 || rq(3) !== 32'h33) begin errors++; $display("FAIL second_write got=%b/%h/%h exp=1/44/33", s_bvalid, rq(4), rq(3)); end
    s_bready = 1'b1; tick(); s_bready = 1'b0;
  endtask

  task automatic test_same_edge_rw();
    logic [1:0] r; logic [15:0] w;
    do_write(0, 32'h1, 4'hF, r, w);
    s_araddr = 12'h000; s_arvalid = 1'b1;
    s_awaddr = 12'h000; s_awvalid = 1'b1;
    s_wdata = 32'h2; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    checks++; if (s_rvalid !== 1'b1 || s_rdata !== 32'h1) begin errors++; $display("FAIL same_edge_read got=%b/%h exp=1/00000001", s_rvalid, s_rdata); end
    checks++; if (s_bvalid !== 1'b1 || rq(0) !== 32'h2) begin errors++; $display("FAIL same_edge_write got=%b/%h exp=1/00000002", s_bvalid, rq(0)); end
    s_rready = 1'b1; s_bready = 1'b1; tick(); s_rready = 1'b0; s_bready = 1'b0;
  endtask

  task automatic test_reset_mid();
    s_araddr = 12'h008; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    s_awaddr = 12'h004; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    checks++; if (s_rvalid !== 1'b1 || s_awready !== 1'b0) begin errors++; $display("FAIL mid_setup got rv=%b awr=%b exp=1/0", s_rvalid, s_awready); end
    rst = 1'b1;
    tick();
    checks++; if ({s_rvalid, s_bvalid, s_awready, s_wready, s_arready} !== 5'b0) begin errors++; $display("FAIL mid_reset_outs got=%b exp=00000", {s_rvalid, s_bvalid, s_awready, s_wready, s_arready}); end
    checks++; if (rq(0) !== 32'h0 || rq(2) !== 32'h0 || rq(4) !== 32'h0) begin errors++; $display("FAIL mid_reset_regs got=%h/%h/%h exp=0", rq(0), rq(2), rq(4)); end
    rst = 1'b0;
    tick();
    checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++; $display("FAIL mid_readys got=%b exp=111", {s_awready, s_wready, s_arready}); end
    s_wdata = 32'h55; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL half_write_dropped got bvalid=%b exp=0", s_bvalid); end
    s_awaddr = 12'h014; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    checks++; if (s_bvalid !== 1'b1 || reg_wr !== 16'h0020 || rq(5) !== 32'h55 || rq(1) !== 32'h0) begin errors++; $display("FAIL post_reset_write got=%b/%h/%h/%h exp=1/0020/55/0", s_bvalid, reg_wr, rq(5), rq(1)); end
    s_bready = 1'b1; tick(); s_bready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_w_first();
    test_errors();
    test_bready_hold();
    test_same_edge_rw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
